en_pipe_reg: RTL and testbench

EN_PIPE_REG -- requirements
Module: en_pipe_reg

---
 rtl/en_pipe_reg.sv | 123 ++++++++++++
 tb/tb_en_pipe_reg.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/en_pipe_reg.sv
// en_pipe_reg: elastic register pipeline of DEPTH stages with valid/ready flow control,
// per-stage bubble collapsing, flush and synchronous reset.
// Optional feature macro: PIPE_OCC_CNT_EN adds the registered occupancy output 'occ'.
module en_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] D,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] Q
`ifdef PIPE_OCC_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             in_xfer;

  // Per-stage advance: a stage moves when some stage at or beyond it is empty, or the
  // output is being drained. This is the flattened form of the recursive "empty, or valid
  // and the next stage advances" rule, which avoids a combinational self-reference.
  always_comb begin
    adv = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      adv[i] = out_rdy | (((~vld_q) >> i) != '0);
    end
  end

  // Upstream handshake: ready only when stage 0 can move and nothing is discarding.
  always_comb begin
    in_rdy  = adv[0] & ~flush & ~rst;
    in_xfer = in_vld & in_rdy;
  end

  // Next-state for valid bits and data; data loads only when the incoming valid is set,
  // so a bubble clears the valid bit but leaves the old data in place.
  always_comb begin
    vld_d = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end
    if (flush) begin
      vld_d = '0;
    end else begin
      if (adv[0]) begin
        vld_d[0] = in_xfer;
        if (in_xfer) begin
          data_d[0] = D;
        end
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  // Stage registers; reset clears both valid bits and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign Q       = data_q[DEPTH-1];

`ifdef PIPE_OCC_CNT_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             out_xfer;

  // Occupancy tracks input-only and output-only transfers; flush empties it.
  always_comb begin
    out_xfer = vld_q[DEPTH-1] & out_rdy;
    occ_d    = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_en_pipe_reg.sv
// Scoreboard bench for en_pipe_reg: four instances (DEPTH 2, 4, 1, 3), one exercised at a time.
module tb_en_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3:0]      flush, in_vld, out_rdy, in_rdy_w, out_vld_w;
  logic [3:0][7:0] d, q_w;
`ifdef PIPE_OCC_CNT_EN
  logic [3:0][7:0] occ_w;
`endif

  int         sel;
  bit         mon_en;
  int         n_tests, n_fail, step;
  logic [7:0] sbq[$];
  logic [7:0] mon_exp;
  string      tag;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int DP = (k == 0) ? 2 : (k == 1) ? 4 : (k == 2) ? 1 : 3;
`ifdef PIPE_OCC_CNT_EN
    logic [$clog2(DP+1)-1:0] occ_loc;
    assign occ_w[k] = 8'(occ_loc);
`endif
    en_pipe_reg #(.WIDTH(8), .DEPTH(DP)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush[k]),
      .in_vld (in_vld[k]),
      .in_rdy (in_rdy_w[k]),
      .D      (d[k]),
      .out_vld(out_vld_w[k]),
      .out_rdy(out_rdy[k]),
      .Q      (q_w[k])
`ifdef PIPE_OCC_CNT_EN
      ,
      .occ    (occ_loc)
`endif
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle on the selected instance; expected values < 0 are not checked.
  task automatic cyc(input int v, input int dat, input int ordy, input int fl,
                     input int e_rdy, input int e_ov, input int e_q, input int e_occ);
    in_vld[sel]  = v[0];
    d[sel]       = dat[7:0];
    out_rdy[sel] = ordy[0];
    flush[sel]   = fl[0];
    @(negedge clk);
    if (e_rdy >= 0) chk($sformatf("%s.c%0d in_rdy", tag, step), 64'(in_rdy_w[sel]), 64'(e_rdy));
    if (e_ov >= 0)  chk($sformatf("%s.c%0d out_vld", tag, step), 64'(out_vld_w[sel]), 64'(e_ov));
    if (e_q >= 0)   chk($sformatf("%s.c%0d Q", tag, step), 64'(q_w[sel]), 64'(e_q));
`ifdef PIPE_OCC_CNT_EN
    if (e_occ >= 0) chk($sformatf("%s.c%0d occ", tag, step), 64'(occ_w[sel]), 64'(e_occ));
`endif
    if (in_vld[sel] && in_rdy_w[sel]) sbq.push_back(d[sel]);
    @(posedge clk);
    #1;
    in_vld[sel] = 1'b0;
    flush[sel]  = 1'b0;
    step++;
  endtask

  task automatic begin_scn(input string t, input int s);
    tag  = t;
    sel  = s;
    step = 0;
  endtask

  task automatic end_scn();
    chk($sformatf("%s drained", tag), 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en && out_vld_w[sel] && out_rdy[sel]) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard: got unexpected output %0h, expected none", tag, q_w[sel]);
      end else begin
        mon_exp = sbq.pop_front();
        if (q_w[sel] !== mon_exp) begin
          n_fail++;
          $display("FAIL %s scoreboard: got %0h expected %0h", tag, q_w[sel], mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; step = 0; sel = 0; mon_en = 1'b0; tag = "rst";
    rst = 1'b1; flush = '0; in_vld = '0; out_rdy = '0; d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst in_rdy[%0d]", k), 64'(in_rdy_w[k]), 64'd0);
      chk($sformatf("rst out_vld[%0d]", k), 64'(out_vld_w[k]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    begin_scn("r031", 0);
    cyc(0, 0, 1, 0,       1, 0, 0, 0);

    begin_scn("s032", 0);
    cyc(1, 'h11, 1, 0,    1, 0, 0, 0);
    cyc(1, 'h22, 1, 0,    1, 0, 0, 1);
    cyc(1, 'h33, 1, 0,    1, 1, 'h11, 2);
    cyc(0, 0, 1, 0,       1, 1, 'h22, 2);
    cyc(0, 0, 1, 0,       1, 1, 'h33, 1);
    cyc(0, 0, 1, 0,       1, 0, 'h33, 0);
    end_scn();

    begin_scn("s033", 0);
    cyc(1, 'hA1, 0, 0,    1, 0, 'h33, 0);
    cyc(1, 'hA2, 0, 0,    1, 0, 'h33, 1);
    cyc(1, 'hA3, 0, 0,    0, 1, 'hA1, 2);
    cyc(1, 'hA3, 1, 0,    1, 1, 'hA1, 2);
    cyc(1, 'hA4, 1, 0,    1, 1, 'hA2, 2);
    cyc(0, 0, 1, 0,       1, 1, 'hA3, 2);
    cyc(0, 0, 1, 0,       1, 1, 'hA4, 1);
    cyc(0, 0, 1, 0,       1, 0, 'hA4, 0);
    end_scn();

    begin_scn("s034", 1);
    cyc(1, 'h41, 0, 0,    1, 0, 0, 0);
    cyc(1, 'h42, 0, 0,    1, 0, 0, 1);
    cyc(1, 'h43, 0, 0,    1, 0, 0, 2);
    cyc(1, 'h44, 0, 0,    1, 0, 0, 3);
    cyc(1, 'h45, 0, 1,    0, 1, 'h41, 4);
    sbq.delete();
    cyc(0, 0, 1, 0,       1, 0, 'h41, 0);
    cyc(0, 0, 1, 0,       1, 0, 'h41, 0);
    cyc(0, 0, 1, 0,       1, 0, 'h41, 0);
    // flush in the same cycle as an output transfer
    cyc(1, 'h51, 0, 0,    1, 0, 'h41, 0);
    cyc(1, 'h52, 0, 0,    1, 0, 'h41, 1);
    cyc(0, 0, 0, 0,       1, 0, 'h41, 2);
    cyc(0, 0, 0, 0,       1, 0, 'h41, 2);
    cyc(0, 0, 1, 1,       0, 1, 'h51, 2);
    sbq.delete();
    cyc(0, 0, 1, 0,       1, 0, 'h51, 0);
    end_scn();

    begin_scn("s035", 2);
    cyc(1, 'h5A, 0, 0,    1, 0, 0, 0);
    cyc(0, 0, 1, 0,       1, 1, 'h5A, 1);
    cyc(1, 'hC3, 0, 0,    1, 0, 'h5A, 0);
    cyc(0, 0, 1, 0,       1, 1, 'hC3, 1);
    cyc(1, 'h5A, 0, 0,    1, 0, 'hC3, 0);
    cyc(0, 0, 1, 0,       1, 1, 'h5A, 1);
    cyc(1, 'hC3, 0, 0,    1, 0, 'h5A, 0);
    cyc(1, 'h5A, 1, 0,    1, 1, 'hC3, 1);
    cyc(1, 'hC3, 0, 0,    0, 1, 'h5A, 1);
    cyc(0, 0, 1, 0,       1, 1, 'h5A, 1);
    cyc(0, 0, 1, 0,       1, 0, 'h5A, 0);
    end_scn();

    begin_scn("s036", 3);
    cyc(1, 'h60, 1, 0,    1, 0, 0, 0);
    cyc(1, 'h61, 0, 0,    1, 0, 0, 1);
    cyc(1, 'h62, 0, 0,    1, 0, 0, 2);
    cyc(0, 0, 1, 0,       1, 1, 'h60, 3);
    rst = 1'b1;
    cyc(1, 'h63, 0, 0,    0, 1, 'h61, 2);
    rst = 1'b0;
    sbq.delete();
    cyc(1, 'h64, 1, 0,    1, 0, 0, 0);
    cyc(0, 0, 1, 0,       1, 0, 0, 1);
    cyc(0, 0, 1, 0,       1, 0, 0, 1);
    cyc(0, 0, 1, 0,       1, 1, 'h64, 1);
    cyc(0, 0, 1, 0,       1, 0, 'h64, 0);
    end_scn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
